// File: rtl/dtc_vote_window.sv
// Majority vote over a window of WIN class predictions (classes 0..3), closed by a full window or by in_flush.
// Optional build macro DTC_VOTE_HIST_EN adds the out_hist port carrying the per-class counts of the voted window.
module dtc_vote_window #(
  parameter  int WIN = 16,
  localparam int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_class,
  input  logic          in_flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_class,
  output logic [CW-1:0] out_count,
  output logic          out_tie
`ifdef DTC_VOTE_HIST_EN
  ,
  output logic [4*CW-1:0] out_hist
`endif
);

  typedef enum logic [1:0] {ACC, RESOLVE, EMIT} state_e;

  localparam logic [CW-1:0] WIN_M1 = CW'(WIN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [CW-1:0] n_q, n_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_class_q, out_class_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          out_tie_q, out_tie_d;
  logic          accept;
  logic [1:0]    best_idx;
  logic [CW-1:0] best_cnt;
  logic          best_tie;

  // Strict '>' lets the lowest class index win a tie for the maximum.
  always_comb begin
    best_idx = 2'd0;
    best_cnt = cnt_q[0];
    best_tie = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (cnt_q[i] > best_cnt) begin
        best_idx = 2'(i);
        best_cnt = cnt_q[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (2'(i) != best_idx && cnt_q[i] == best_cnt) best_tie = 1'b1;
    end
  end

  assign accept = in_valid & in_ready_q;

  // NOTE: every next-state value gets its default first, so no path through the case leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_count_d = out_count_q;
    out_tie_d   = out_tie_q;
    unique case (state_q)
      ACC: begin
        if (accept) begin
          cnt_d[in_class] = cnt_q[in_class] + 1'b1;
          n_d             = n_q + 1'b1;
        end
        if ((accept && n_q == WIN_M1) || (in_flush && (n_q != '0 || accept)))
          state_d = RESOLVE;
      end
      RESOLVE: begin
        out_class_d = best_idx;
        out_count_d = best_cnt;
        out_tie_d   = best_tie;
        out_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          for (int i = 0; i < 4; i++) cnt_d[i] = '0;
          n_d     = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    in_ready_d = (state_d == ACC);
  end

  // NOTE: the four-entry count array is tiny state, so it is reset with everything else rather than left uninitialised like a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      n_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= 2'd0;
      out_count_q <= '0;
      out_tie_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_count_q <= out_count_d;
      out_tie_q   <= out_tie_d;
    end
  end

`ifdef DTC_VOTE_HIST_EN
  logic [4*CW-1:0] out_hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    out_hist_q <= '0;
    else if (state_q == RESOLVE) out_hist_q <= {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
  end

  assign out_hist = out_hist_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_count = out_count_q;
  assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_dtc_vote_window.sv
// Directed bench for dtc_vote_window: table of windows with hand-computed votes, plus hold, idle-flush and mid-window reset sequences.
// Compile with DTC_VOTE_HIST_EN defined to also compare out_hist.
module tb_dtc_vote_window;

  localparam int WIN = 16;
  localparam int CW  = $clog2(WIN + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_class;
  logic          in_flush;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_class;
  logic [CW-1:0] out_count;
  logic          out_tie;
`ifdef DTC_VOTE_HIST_EN
  logic [4*CW-1:0] out_hist;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dtc_vote_window #(.WIN(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .out_tie   (out_tie)
`ifdef DTC_VOTE_HIST_EN
    ,
    .out_hist  (out_hist)
`endif
  );

  always #5 clk = ~clk;

  // One window: sample i has class pat[2i+1:2i]; h3..h0 are the expected per-class counts.
  typedef struct {
    int          n;
    logic [31:0] pat;
    bit          flush_last;
    logic [1:0]  e_class;
    int          e_count;
    bit          e_tie;
    int          h3, h2, h1, h0;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hist_of(input int h3, input int h2, input int h1, input int h0);
    logic [4*CW-1:0] h;
    h = {CW'(h3), CW'(h2), CW'(h1), CW'(h0)};
    return 32'(h);
  endfunction

  // Drives n samples on consecutive accepting cycles; returns #1 after the edge that accepts the last.
  task automatic feed(input int n, input logic [31:0] pat, input bit flush_last);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (!in_ready && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      check("in_ready_before_sample", in_ready, 1);
      in_valid = 1'b1;
      in_class = pat[2*i +: 2];
      in_flush = flush_last && (i == n - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_flush = 1'b0;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_release", out_valid, 0);
    check("in_ready_after_release", in_ready, 1);
  endtask

  // Called right after feed(): result must appear exactly one edge later (two edges from the closing accept).
  task automatic expect_result(input string name, input logic [1:0] e_class, input int e_count,
                               input bit e_tie, input logic [31:0] e_hist, input bit do_release);
    check({name, "_valid_edge1"}, out_valid, 0);
    check({name, "_ready_resolve"}, in_ready, 0);
    @(posedge clk); #1;
    check({name, "_valid_edge2"}, out_valid, 1);
    check({name, "_class"}, out_class, e_class);
    check({name, "_count"}, out_count, e_count);
    check({name, "_tie"}, out_tie, e_tie);
    check({name, "_ready_emit"}, in_ready, 0);
`ifdef DTC_VOTE_HIST_EN
    check({name, "_hist"}, out_hist, e_hist);
`else
    if (e_hist === 32'hx) $display("unexpected x in expected histogram");
`endif
    if (do_release) release_out();
  endtask

  initial begin
    vecs[0] = '{16, 32'h6A6A_6A6A, 1'b0, 2'd2, 12, 1'b0, 0, 12, 4, 0};  // 2,2,2,1 x4
    vecs[1] = '{16, 32'h5555_FFFF, 1'b0, 2'd1,  8, 1'b1, 8, 0, 8, 0};   // 8x3 then 8x1
    vecs[2] = '{ 6, 32'h0000_0000, 1'b1, 2'd0,  6, 1'b0, 0, 0, 0, 6};   // 6x0, flush with 6th
    vecs[3] = '{16, 32'hFFAA_9500, 1'b0, 2'd2,  5, 1'b0, 4, 5, 3, 4};   // 4,3,5,4 of 0..3
    vecs[4] = '{16, 32'hFFFF_FFFF, 1'b0, 2'd3, 16, 1'b0, 16, 0, 0, 0};  // count reaches WIN
    vecs[5] = '{ 1, 32'h0000_0001, 1'b1, 2'd1,  1, 1'b0, 0, 0, 1, 0};   // single sample + flush
    vecs[6] = '{ 4, 32'h0000_00F0, 1'b1, 2'd0,  2, 1'b1, 2, 0, 0, 2};   // 0,0,3,3 tie -> lowest

    rst = 1'b1; in_valid = 1'b0; in_class = 2'd0; in_flush = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_class", out_class, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_tie", out_tie, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Flush with an empty window must be ignored.
    in_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_flush_no_valid", out_valid, 0);
      check("idle_flush_ready", in_ready, 1);
    end
    in_flush = 1'b0;
    @(posedge clk); #1;
    check("idle_flush_after", out_valid, 0);

    for (int v = 0; v < 7; v++) begin
      feed(vecs[v].n, vecs[v].pat, vecs[v].flush_last);
      expect_result($sformatf("vec%0d", v), vecs[v].e_class, vecs[v].e_count, vecs[v].e_tie,
                    hist_of(vecs[v].h3, vecs[v].h2, vecs[v].h1, vecs[v].h0), 1'b1);
    end

    // Backpressure: result held for 10 cycles, then counts restart from zero.
    feed(16, 32'h6A6A_6A6A, 1'b0);
    expect_result("hold", 2'd2, 12, 1'b0, hist_of(0, 12, 4, 0), 1'b0);
    in_valid = 1'b1;
    in_class = 2'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_class", out_class, 2);
      check("hold_count", out_count, 12);
      check("hold_tie", out_tie, 0);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();
    feed(2, 32'h0000_0005, 1'b1);
    expect_result("after_hold", 2'd1, 2, 1'b0, hist_of(0, 0, 2, 0), 1'b1);

    // Reset mid-window: the 7 class-3 samples must vanish.
    feed(7, 32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    #2;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst_no_emit", out_valid, 0);
    end
    feed(16, 32'hFFFF_0000, 1'b0);
    expect_result("post_rst", 2'd0, 8, 1'b1, hist_of(8, 0, 0, 8), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
